// File: rtl/maxnet_data_memory.sv
// ---------------------------------------------------------------------------
// maxnet_data_memory
//
// Activation store for the Maxnet datapath. Holds N_CH entries of DATA_W bits
// and copies them in from an initialisation image one entry per cycle after
// reset or on request. Also accepts full-vector write-back with optional
// negative clamping. It tracks the number of surviving (nonzero) entries so
// the controller can tell when a single winner is left.
//
// The initialisation image is passed in as the INIT_DATA parameter, with
// entry i at [i*DATA_W +: DATA_W]. It is the contents of the hex image file,
// packed, so the ROM elaborates to constants with no file access.
//
// Ports
//   i_clk            rising-edge clock
//   i_rst            asynchronous reset, active low
//   i_reload         single-cycle request to restart the load sequence
//   o_busy           load sequence in progress
//   i_wr_en          write full vector
//   i_wr_data        write vector, entry i at [i*DATA_W +: DATA_W]
//   o_wr_err         one-cycle pulse: a write was dropped (busy or reload)
//   o_rd_data        all entries, straight from the array
//   i_rd_addr        single-entry read address
//   i_rd_req         single-entry read request
//   o_rd_single      registered single-entry read data
//   o_rd_valid       o_rd_single valid for one cycle
//   o_nz_count       number of nonzero entries (one cycle behind the array)
//   o_winner_found   exactly one nonzero entry
//   o_winner_idx     index of that entry, 0 when no winner
//
// state   | meaning
// --------+------------------------------------------------------------
// ST_LOAD | copying init image entry r_idx into the array, busy
// ST_IDLE | array holds live data, writes accepted
// ---------------------------------------------------------------------------
module maxnet_data_memory #(
   parameter int                       N_CH      = 4,
   parameter int                       DATA_W    = 4,
   parameter logic [N_CH*DATA_W-1:0]   INIT_DATA = 16'h5273,
   parameter bit                       CLAMP_NEG = 1'b1,
   parameter int                       IDX_W     = $clog2(N_CH),
   parameter int                       CNT_W     = $clog2(N_CH+1)
) (
   input  logic                     i_clk,
   input  logic                     i_rst,
   input  logic                     i_reload,
   output logic                     o_busy,
   input  logic                     i_wr_en,
   input  logic [N_CH*DATA_W-1:0]   i_wr_data,
   output logic                     o_wr_err,
   output logic [N_CH*DATA_W-1:0]   o_rd_data,
   input  logic [IDX_W-1:0]         i_rd_addr,
   input  logic                     i_rd_req,
   output logic [DATA_W-1:0]        o_rd_single,
   output logic                     o_rd_valid,
   output logic [CNT_W-1:0]         o_nz_count,
   output logic                     o_winner_found,
   output logic [IDX_W-1:0]         o_winner_idx
);

   typedef enum logic {ST_LOAD, ST_IDLE} state_t;

   state_t              r_state;
   state_t              w_state_nxt;
   logic [IDX_W-1:0]    r_idx;
   logic [IDX_W-1:0]    w_idx_nxt;
   logic [IDX_W-1:0]    w_load_addr;
   logic                w_load_en;
   logic                w_wr_en;
   logic                w_last;

   logic [DATA_W-1:0]   r_mem    [N_CH];
   logic [DATA_W-1:0]   w_rom    [N_CH];
   logic [DATA_W-1:0]   w_wr_val [N_CH];

   logic                r_wr_err;
   logic [DATA_W-1:0]   r_rd_single;
   logic                r_rd_valid;
   logic [CNT_W-1:0]    r_nz_count;
   logic                r_winner_found;
   logic [IDX_W-1:0]    r_winner_idx;

   logic [CNT_W-1:0]    w_nz_count;
   logic [IDX_W-1:0]    w_first_nz;
   logic                w_seen_nz;

   for (genvar g = 0; g < N_CH; g++) begin : g_entry
      assign w_rom[g]     = INIT_DATA[g*DATA_W +: DATA_W];
      // A set MSB is a negative two's-complement value; Maxnet treats those as dead.
      assign w_wr_val[g]  = (CLAMP_NEG && i_wr_data[g*DATA_W + DATA_W - 1]) ?
                            '0 : i_wr_data[g*DATA_W +: DATA_W];
      assign o_rd_data[g*DATA_W +: DATA_W] = r_mem[g];
   end

   assign w_last = (r_idx == IDX_W'(N_CH - 1));
   assign o_busy = (r_state == ST_LOAD);

   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         r_state <= ST_LOAD;
         r_idx   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_idx   <= w_idx_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_idx_nxt   = r_idx;
      w_load_en   = 1'b0;
      w_load_addr = r_idx;
      w_wr_en     = 1'b0;
      case (r_state)
         ST_LOAD: begin
            w_load_en = 1'b1;
            if (i_reload) begin
               // Restart: this edge rewrites entry 0, then the walk begins again at 0.
               w_load_addr = '0;
               w_idx_nxt   = '0;
            end else if (w_last) begin
               w_state_nxt = ST_IDLE;
               w_idx_nxt   = '0;
            end else begin
               w_idx_nxt = r_idx + IDX_W'(1);
            end
         end
         ST_IDLE: begin
            if (i_reload) begin
               // The array keeps its contents until each entry is recopied.
               w_state_nxt = ST_LOAD;
               w_idx_nxt   = '0;
            end else if (i_wr_en) begin
               w_wr_en = 1'b1;
            end
         end
         default: begin
            w_state_nxt = ST_LOAD;
            w_idx_nxt   = '0;
         end
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         for (int i = 0; i < N_CH; i++) r_mem[i] <= '0;
      end else if (w_wr_en) begin
         for (int i = 0; i < N_CH; i++) r_mem[i] <= w_wr_val[i];
      end else if (w_load_en) begin
         r_mem[w_load_addr] <= w_rom[w_load_addr];
      end
   end

   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         r_wr_err    <= 1'b0;
         r_rd_single <= '0;
         r_rd_valid  <= 1'b0;
      end else begin
         r_wr_err   <= i_wr_en && ((r_state == ST_LOAD) || i_reload);
         r_rd_valid <= i_rd_req;
         if (i_rd_req) begin
            r_rd_single <= (int'(i_rd_addr) < N_CH) ? r_mem[i_rd_addr] : '0;
         end
      end
   end

   always_comb begin
      w_nz_count = '0;
      w_first_nz = '0;
      w_seen_nz  = 1'b0;
      for (int i = 0; i < N_CH; i++) begin
         if (r_mem[i] != '0) begin
            w_nz_count = w_nz_count + CNT_W'(1);
            if (!w_seen_nz) begin
               w_first_nz = IDX_W'(i);
               w_seen_nz  = 1'b1;
            end
         end
      end
   end

   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         r_nz_count     <= '0;
         r_winner_found <= 1'b0;
         r_winner_idx   <= '0;
      end else begin
         r_nz_count     <= w_nz_count;
         r_winner_found <= (w_nz_count == CNT_W'(1));
         r_winner_idx   <= (w_nz_count == CNT_W'(1)) ? w_first_nz : '0;
      end
   end

   assign o_wr_err       = r_wr_err;
   assign o_rd_single    = r_rd_single;
   assign o_rd_valid     = r_rd_valid;
   assign o_nz_count     = r_nz_count;
   assign o_winner_found = r_winner_found;
   assign o_winner_idx   = r_winner_idx;

endmodule

// File: tb/tb_maxnet_data_memory.sv
// ---------------------------------------------------------------------------
// tb_maxnet_data_memory
//
// Two instances share all inputs: u_dut clamps negative writes, u_nc does
// not. Both load the image 3,7,2,5 (entry 0 first).
// ---------------------------------------------------------------------------
module tb_maxnet_data_memory;

   localparam int N_CH   = 4;
   localparam int DATA_W = 4;
   localparam int IDX_W  = 2;
   localparam int CNT_W  = 3;
   localparam logic [15:0] IMAGE = 16'h5273;

   logic               clk;
   logic               rst;
   logic               reload;
   logic               wr_en;
   logic [15:0]        wr_data;
   logic [IDX_W-1:0]   rd_addr;
   logic               rd_req;

   logic               busy_c,   busy_n;
   logic               wr_err_c, wr_err_n;
   logic [15:0]        rd_data_c, rd_data_n;
   logic [3:0]         rd_single_c, rd_single_n;
   logic               rd_valid_c, rd_valid_n;
   logic [CNT_W-1:0]   nz_c, nz_n;
   logic               win_c, win_n;
   logic [IDX_W-1:0]   widx_c, widx_n;

   int checks   = 0;
   int failures = 0;

   maxnet_data_memory #(.N_CH(N_CH), .DATA_W(DATA_W), .INIT_DATA(IMAGE), .CLAMP_NEG(1'b1)) u_dut (
      .i_clk(clk), .i_rst(rst), .i_reload(reload), .o_busy(busy_c),
      .i_wr_en(wr_en), .i_wr_data(wr_data), .o_wr_err(wr_err_c),
      .o_rd_data(rd_data_c), .i_rd_addr(rd_addr), .i_rd_req(rd_req),
      .o_rd_single(rd_single_c), .o_rd_valid(rd_valid_c),
      .o_nz_count(nz_c), .o_winner_found(win_c), .o_winner_idx(widx_c));

   maxnet_data_memory #(.N_CH(N_CH), .DATA_W(DATA_W), .INIT_DATA(IMAGE), .CLAMP_NEG(1'b0)) u_nc (
      .i_clk(clk), .i_rst(rst), .i_reload(reload), .o_busy(busy_n),
      .i_wr_en(wr_en), .i_wr_data(wr_data), .o_wr_err(wr_err_n),
      .o_rd_data(rd_data_n), .i_rd_addr(rd_addr), .i_rd_req(rd_req),
      .o_rd_single(rd_single_n), .o_rd_valid(rd_valid_n),
      .o_nz_count(nz_n), .o_winner_found(win_n), .o_winner_idx(widx_n));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   typedef struct {
      logic [15:0]      wd;
      logic [15:0]      mem_c;
      logic [CNT_W-1:0] nz_c;
      logic             win_c;
      logic [IDX_W-1:0] idx_c;
      logic [15:0]      mem_n;
      logic [CNT_W-1:0] nz_n;
      logic             win_n;
      logic [IDX_W-1:0] idx_n;
   } wvec_t;

   wvec_t       wv [6];
   logic [15:0] ramp [4];

   initial begin
      int n;

      // entry 3..0 nibbles, high to low
      wv[0] = '{16'hFE51, 16'h0051, 3'd2, 1'b0, 2'd0, 16'hFE51, 3'd4, 1'b0, 2'd0};
      wv[1] = '{16'h0030, 16'h0030, 3'd1, 1'b1, 2'd1, 16'h0030, 3'd1, 1'b1, 2'd1};
      wv[2] = '{16'h0000, 16'h0000, 3'd0, 1'b0, 2'd0, 16'h0000, 3'd0, 1'b0, 2'd0};
      wv[3] = '{16'h8000, 16'h0000, 3'd0, 1'b0, 2'd0, 16'h8000, 3'd1, 1'b1, 2'd3};
      wv[4] = '{16'h0700, 16'h0700, 3'd1, 1'b1, 2'd2, 16'h0700, 3'd1, 1'b1, 2'd2};
      wv[5] = '{16'h1234, 16'h1234, 3'd4, 1'b0, 2'd0, 16'h1234, 3'd4, 1'b0, 2'd0};
      ramp[0] = 16'h0003;
      ramp[1] = 16'h0073;
      ramp[2] = 16'h0273;
      ramp[3] = 16'h5273;

      rst = 1'b0; reload = 1'b0; wr_en = 1'b0; wr_data = '0; rd_addr = '0; rd_req = 1'b0;

      // reset state
      @(negedge clk); @(negedge clk);
      chk("rst_busy", busy_c, 1);
      chk("rst_data", rd_data_c, 0);
      chk("rst_nz", nz_c, 0);
      chk("rst_win", win_c, 0);
      chk("rst_widx", widx_c, 0);
      chk("rst_wr_err", wr_err_c, 0);
      chk("rst_rd_valid", rd_valid_c, 0);
      chk("rst_rd_single", rd_single_c, 0);

      // initial load ramp
      rst = 1'b1;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         chk($sformatf("load_data_%0d", k), rd_data_c, ramp[k]);
         chk($sformatf("load_busy_%0d", k), busy_c, (k < 3) ? 1 : 0);
      end
      @(negedge clk);
      chk("load_nz", nz_c, 4);
      chk("load_win", win_c, 0);

      // full-vector writes, both clamp settings
      for (int v = 0; v < 6; v++) begin
         wr_en = 1'b1; wr_data = wv[v].wd;
         @(negedge clk);
         wr_en = 1'b0;
         chk($sformatf("wr%0d_mem_c", v), rd_data_c, wv[v].mem_c);
         chk($sformatf("wr%0d_mem_n", v), rd_data_n, wv[v].mem_n);
         chk($sformatf("wr%0d_err", v), wr_err_c, 0);
         @(negedge clk);
         chk($sformatf("wr%0d_nz_c", v), nz_c, wv[v].nz_c);
         chk($sformatf("wr%0d_win_c", v), win_c, wv[v].win_c);
         chk($sformatf("wr%0d_idx_c", v), widx_c, wv[v].idx_c);
         chk($sformatf("wr%0d_nz_n", v), nz_n, wv[v].nz_n);
         chk($sformatf("wr%0d_win_n", v), win_n, wv[v].win_n);
         chk($sformatf("wr%0d_idx_n", v), widx_n, wv[v].idx_n);
      end

      // reload and wr_en together: reload wins, write dropped
      reload = 1'b1; wr_en = 1'b1; wr_data = 16'h1111;
      @(negedge clk);
      reload = 1'b0; wr_en = 1'b0;
      chk("rw_busy", busy_c, 1);
      chk("rw_err", wr_err_c, 1);
      chk("rw_data_kept", rd_data_c, 16'h1234);
      @(negedge clk);
      chk("rw_err_pulse", wr_err_c, 0);
      chk("rw_first_copy", rd_data_c, 16'h1233);
      n = 0;
      while (busy_c && n < 10) begin
         @(negedge clk);
         n++;
      end
      chk("rw_load_done", busy_c, 0);
      chk("rw_load_data", rd_data_c, IMAGE);

      // reload during load restarts the walk at entry 0
      reload = 1'b1;
      @(negedge clk);
      reload = 1'b0;
      @(negedge clk);
      @(negedge clk);
      reload = 1'b1;
      @(negedge clk);
      reload = 1'b0;
      chk("rl_busy", busy_c, 1);
      n = 0;
      while (busy_c && n < 10) begin
         @(negedge clk);
         n++;
      end
      chk("rl_restart_cycles", n, 4);
      chk("rl_data", rd_data_c, IMAGE);

      // async reset in the middle of a load
      reload = 1'b1;
      @(negedge clk);
      reload = 1'b0;
      @(negedge clk);
      @(negedge clk);
      #2 rst = 1'b0;
      #1;
      chk("arst_data_c", rd_data_c, 0);
      chk("arst_data_n", rd_data_n, 0);
      chk("arst_busy", busy_c, 1);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      chk("arst_load0", rd_data_c, 16'h0003);
      wr_en = 1'b1; wr_data = 16'hFFFF;
      @(negedge clk);
      wr_en = 1'b0;
      chk("ld_wr_err", wr_err_c, 1);
      chk("ld_wr_data", rd_data_c, 16'h0073);
      @(negedge clk);
      chk("ld_wr_err_pulse", wr_err_c, 0);
      chk("ld_wr_data2", rd_data_c, 16'h0273);
      @(negedge clk);
      chk("arst_load_done", busy_c, 0);
      chk("arst_load_data", rd_data_c, IMAGE);

      // single-entry reads, including read-before-write on the same edge
      rd_req = 1'b1; rd_addr = 2'd3;
      @(negedge clk);
      chk("rd_single", rd_single_c, 4'h5);
      chk("rd_valid", rd_valid_c, 1);
      wr_en = 1'b1; wr_data = 16'h9273;
      @(negedge clk);
      wr_en = 1'b0;
      chk("rd_old_c", rd_single_c, 4'h5);
      chk("rd_old_n", rd_single_n, 4'h5);
      @(negedge clk);
      rd_req = 1'b0;
      chk("rd_new_c", rd_single_c, 4'h0);
      chk("rd_new_n", rd_single_n, 4'h9);
      @(negedge clk);
      chk("rd_valid_drop", rd_valid_c, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
